bus_rr_source: RTL and testbench

Two-requester round-robin source stage that sits directly upstream of the team's 4-bit 2:1 bus mux. It accepts 4-bit words from two valid/ready requesters, A and B, and holds the winner's word in that requester's bus register. It drives the mux select (0 = A on mux `in_1`, 1 = B on mux `in_2`) together with an output valid/ready handshake. The mux output therefore always equals the held winner word while `out_valid` is high.

---
 rtl/bus_rr_source.sv | 102 ++++++++++
 tb/tb_bus_rr_source.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_source.sv
// Two-requester round-robin source stage feeding a 2:1 bus mux.
// Holds the winning word in its requester's bus register and drives the mux select.
module bus_rr_source #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic [WIDTH-1:0] bus_a,
  output logic [WIDTH-1:0] bus_b,
  output logic             sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] gnt_cnt_a,
  output logic [CNT_W-1:0] gnt_cnt_b
);

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [WIDTH-1:0] BUS_ZERO = {WIDTH{1'b0}};

  logic             out_valid_r;
  logic             sel_r;
  logic             last_r;       // 1'b0 = A granted last, 1'b1 = B granted last
  logic [WIDTH-1:0] bus_a_r;
  logic [WIDTH-1:0] bus_b_r;
  logic [CNT_W-1:0] gnt_cnt_a_r;
  logic [CNT_W-1:0] gnt_cnt_b_r;

  logic slot_free_s;
  logic gnt_a_s;
  logic gnt_b_s;
  logic acc_a_s;
  logic acc_b_s;

  // Round-robin grant and ready generation; readies are suppressed while reset is high.
  always_comb begin
    slot_free_s = ~out_valid_r | out_ready;
    gnt_a_s     = 1'b0;
    gnt_b_s     = 1'b0;
    if (a_valid && b_valid) begin
      gnt_a_s = last_r;
      gnt_b_s = ~last_r;
    end else begin
      gnt_a_s = a_valid;
      gnt_b_s = b_valid;
    end
    if (reset) begin
      acc_a_s = 1'b0;
      acc_b_s = 1'b0;
    end else begin
      acc_a_s = slot_free_s & gnt_a_s;
      acc_b_s = slot_free_s & gnt_b_s;
    end
  end

  // Output register, grant history and per-requester counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      sel_r       <= 1'b0;
      last_r      <= 1'b1;
      bus_a_r     <= BUS_ZERO;
      bus_b_r     <= BUS_ZERO;
      gnt_cnt_a_r <= CNT_ZERO;
      gnt_cnt_b_r <= CNT_ZERO;
    end else if (acc_a_s) begin
      bus_a_r     <= a_data;
      sel_r       <= 1'b0;
      out_valid_r <= 1'b1;
      last_r      <= 1'b0;
      gnt_cnt_a_r <= gnt_cnt_a_r + CNT_ONE;
    end else if (acc_b_s) begin
      bus_b_r     <= b_data;
      sel_r       <= 1'b1;
      out_valid_r <= 1'b1;
      last_r      <= 1'b1;
      gnt_cnt_b_r <= gnt_cnt_b_r + CNT_ONE;
    end else if (out_valid_r && out_ready) begin
      // Word consumed with nothing to replace it; buses and select keep their values.
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign a_ready   = acc_a_s;
  assign b_ready   = acc_b_s;
  assign out_valid = out_valid_r;
  assign sel       = sel_r;
  assign bus_a     = bus_a_r;
  assign bus_b     = bus_b_r;
  assign gnt_cnt_a = gnt_cnt_a_r;
  assign gnt_cnt_b = gnt_cnt_b_r;

endmodule

// File: tb/tb_bus_rr_source.sv
// Self-checking bench for bus_rr_source: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_bus_rr_source;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;
  localparam int CNT_MOD = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             reset;
  logic             a_valid, b_valid, out_ready;
  logic [WIDTH-1:0] a_data, b_data;
  logic             a_ready, b_ready, sel, out_valid;
  logic [WIDTH-1:0] bus_a, bus_b;
  logic [CNT_W-1:0] gnt_cnt_a, gnt_cnt_b;

  int checks = 0;
  int errors = 0;

  // Behavioural model state (last: 0 = A, 1 = B)
  int m_valid, m_sel, m_bus_a, m_bus_b, m_cnt_a, m_cnt_b, m_last;
  int m_acc_a, m_acc_b;

  always #5 clk = ~clk;

  bus_rr_source #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .bus_a(bus_a), .bus_b(bus_b), .sel(sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .gnt_cnt_a(gnt_cnt_a), .gnt_cnt_b(gnt_cnt_b)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_sel = 0; m_bus_a = 0; m_bus_b = 0;
    m_cnt_a = 0; m_cnt_b = 0; m_last = 1;
  endtask

  // One clock: check outputs at the falling edge, then advance the model across the rising edge.
  task automatic cycle();
    int ea, eb, free;
    @(negedge clk);
    ea = 0; eb = 0;
    if (!reset) begin
      free = (m_valid == 0 || out_ready) ? 1 : 0;
      if (a_valid && b_valid) begin
        if (m_last == 1) ea = free;
        else eb = free;
      end else begin
        ea = (free != 0 && a_valid) ? 1 : 0;
        eb = (free != 0 && b_valid) ? 1 : 0;
      end
    end
    check("a_ready", int'(a_ready), ea);
    check("b_ready", int'(b_ready), eb);
    check("out_valid", int'(out_valid), m_valid);
    check("sel", int'(sel), m_sel);
    check("bus_a", int'(bus_a), m_bus_a);
    check("bus_b", int'(bus_b), m_bus_b);
    check("gnt_cnt_a", int'(gnt_cnt_a), m_cnt_a);
    check("gnt_cnt_b", int'(gnt_cnt_b), m_cnt_b);
    m_acc_a = ea;
    m_acc_b = eb;
    if (reset) begin
      model_reset();
    end else if (ea != 0) begin
      m_bus_a = int'(a_data); m_sel = 0; m_valid = 1; m_last = 0;
      m_cnt_a = (m_cnt_a + 1) % CNT_MOD;
    end else if (eb != 0) begin
      m_bus_b = int'(b_data); m_sel = 1; m_valid = 1; m_last = 1;
      m_cnt_b = (m_cnt_b + 1) % CNT_MOD;
    end else if (m_valid != 0 && out_ready) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
    a_data = 4'h0; b_data = 4'h0;
    @(posedge clk);
    #1;
    model_reset();
    do_reset();

    // Reset state
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_sel", int'(sel), 0);
    check("rst_cnt_a", int'(gnt_cnt_a), 0);
    check("rst_bus_b", int'(bus_b), 0);

    // A only
    a_valid = 1'b1; a_data = 4'h5; out_ready = 1'b1;
    cycle();
    a_valid = 1'b0;
    check("t1_out_valid", int'(out_valid), 1);
    check("t1_sel", int'(sel), 0);
    check("t1_bus_a", int'(bus_a), 5);
    check("t1_cnt_a", int'(gnt_cnt_a), 1);
    check("t1_bus_b", int'(bus_b), 0);

    // Contention from a fresh reset: A, B, A, B
    do_reset();
    a_valid = 1'b1; a_data = 4'h3; b_valid = 1'b1; b_data = 4'hC; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("t2_sel_seq", int'(sel), i % 2);
      if (i == 1) check("t2_bus_a_hold", int'(bus_a), 3);
    end
    check("t2_cnt_a", int'(gnt_cnt_a), 2);
    check("t2_cnt_b", int'(gnt_cnt_b), 2);

    // Stall with both valid
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t3_a_ready", int'(a_ready), 0);
      check("t3_b_ready", int'(b_ready), 0);
    end
    check("t3_sel", int'(sel), 1);
    check("t3_bus_a", int'(bus_a), 3);
    check("t3_bus_b", int'(bus_b), 12);
    check("t3_cnt_a", int'(gnt_cnt_a), 2);
    check("t3_cnt_b", int'(gnt_cnt_b), 2);
    out_ready = 1'b1;
    #1;
    check("t3_release_a_ready", int'(a_ready), 1);
    check("t3_release_b_ready", int'(b_ready), 0);
    cycle();

    // Simultaneous handshake and accept: A=1 held, then B=E replaces it with no bubble
    b_valid = 1'b0; a_data = 4'h1;
    cycle();
    check("t4_hold_a", int'(bus_a), 1);
    a_valid = 1'b0; b_valid = 1'b1; b_data = 4'hE;
    cycle();
    b_valid = 1'b0;
    check("t4_out_valid", int'(out_valid), 1);
    check("t4_sel", int'(sel), 1);
    check("t4_bus_b", int'(bus_b), 14);

    // Counter wrap after 256 A accepts
    do_reset();
    a_valid = 1'b1; a_data = 4'h7; out_ready = 1'b1;
    for (int i = 0; i < 256; i++) cycle();
    a_valid = 1'b0;
    check("t5_cnt_a_wrap", int'(gnt_cnt_a), 0);
    check("t5_cnt_b", int'(gnt_cnt_b), 0);

    // Reset mid-operation with B holding 9
    b_valid = 1'b1; b_data = 4'h9;
    cycle();
    check("t6_sel", int'(sel), 1);
    check("t6_bus_b", int'(bus_b), 9);
    reset = 1'b1;
    #1;
    check("t6_b_ready_in_reset", int'(b_ready), 0);
    cycle();
    reset = 1'b0;
    check("t6_out_valid", int'(out_valid), 0);
    check("t6_bus_b_rst", int'(bus_b), 0);
    check("t6_cnt_a", int'(gnt_cnt_a), 0);
    a_valid = 1'b1; a_data = 4'h2;
    #1;
    check("t6_first_contest_a", int'(a_ready), 1);
    check("t6_first_contest_b", int'(b_ready), 0);
    cycle();

    // Randomized traffic; requesters hold their word until it is accepted
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0;
      out_ready = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
      if (!a_valid || m_acc_a != 0) begin
        a_valid = ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0;
        a_data = WIDTH'($urandom);
      end
      if (!b_valid || m_acc_b != 0) begin
        b_valid = ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0;
        b_data = WIDTH'($urandom);
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
